// File: rtl/dram16_arb_ctrl.sv
// dram16_arb_ctrl: arbitrates an instruction read port and a data load/store
// port onto a 16-bit asynchronous-read DRAM, splitting each 32-bit word into
// two halfword cycles and doing read-modify-write for partial-halfword stores.
module dram16_arb_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [16:0] mem_addr,
  output logic        mem_we,
  inout  wire  [15:0] mem_data
);

  typedef enum logic [2:0] {IDLE, LO_RD, LO_WR, HI_RD, HI_WR, RESP} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_base;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_isD;
  logic        r_lastD;
  logic [31:0] r_buf;
  logic        r_iAck;
  logic        r_dAck;
  logic [31:0] r_iRdata;
  logic [31:0] r_dRdata;

  logic        w_grantD;
  logic        w_grantI;
  logic        w_respIsD;
  logic        w_hiSel;
  logic [15:0] w_wrHalf;
  logic [15:0] w_mergeLo;
  logic [15:0] w_mergeHi;
  logic        w_unused;

  // Entry state for the high halfword of a store, chosen by its byte-enable pair.
  function automatic state_t hiEntry(input logic [3:0] be);
    if (be[3:2] == 2'b11)      return HI_WR;
    else if (be[3:2] != 2'b00) return HI_RD;
    else                       return RESP;
  endfunction

  // Entry state for a store; falls through to the high half when the low pair is empty.
  function automatic state_t loEntry(input logic [3:0] be);
    if (be[1:0] == 2'b11)      return LO_WR;
    else if (be[1:0] != 2'b00) return LO_RD;
    else                       return hiEntry(be);
  endfunction

  // Data wins a conflict unless it was the last port granted.
  assign w_grantD  = d_req && (!i_req || !r_lastD);
  assign w_grantI  = i_req && !w_grantD;
  assign w_respIsD = (r_state == IDLE) ? w_grantD : r_isD;

  // Unselected bytes come from the halfword fetched in the preceding RD state.
  assign w_mergeLo = {r_be[1] ? r_wdata[15:8]  : r_buf[15:8],
                      r_be[0] ? r_wdata[7:0]   : r_buf[7:0]};
  assign w_mergeHi = {r_be[3] ? r_wdata[31:24] : r_buf[31:24],
                      r_be[2] ? r_wdata[23:16] : r_buf[23:16]};

  assign mem_data = mem_we ? w_wrHalf : 16'bz;
  assign i_ack    = r_iAck;
  assign d_ack    = r_dAck;
  assign i_rdata  = r_iRdata;
  assign d_rdata  = r_dRdata;

  assign w_unused = ^{i_addr[31:18], i_addr[1:0], d_addr[31:18], d_addr[1:0]};

  // Next-state sequencing and DRAM-side outputs decoded from the current state.
  always_comb begin
    w_nextState = r_state;
    mem_we      = 1'b0;
    w_hiSel     = 1'b0;
    w_wrHalf    = 16'h0000;
    case (r_state)
      IDLE: begin
        if (w_grantD)      w_nextState = d_we ? loEntry(d_be) : LO_RD;
        else if (w_grantI) w_nextState = LO_RD;
      end
      LO_RD: w_nextState = r_we ? LO_WR : HI_RD;
      LO_WR: begin
        mem_we      = 1'b1;
        w_wrHalf    = w_mergeLo;
        w_nextState = hiEntry(r_be);
      end
      HI_RD: begin
        w_hiSel     = 1'b1;
        w_nextState = r_we ? HI_WR : RESP;
      end
      HI_WR: begin
        mem_we      = 1'b1;
        w_hiSel     = 1'b1;
        w_wrHalf    = w_mergeHi;
        w_nextState = RESP;
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    mem_addr = {r_base, w_hiSel};
  end

  // State register, request latching, halfword capture and ack/rdata registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_base   <= 16'h0000;
      r_we     <= 1'b0;
      r_wdata  <= 32'h0;
      r_be     <= 4'h0;
      r_isD    <= 1'b0;
      r_lastD  <= 1'b0;
      r_buf    <= 32'h0;
      r_iAck   <= 1'b0;
      r_dAck   <= 1'b0;
      r_iRdata <= 32'h0;
      r_dRdata <= 32'h0;
    end else begin
      r_state <= w_nextState;
      r_iAck  <= (w_nextState == RESP) && !w_respIsD;
      r_dAck  <= (w_nextState == RESP) && w_respIsD;
      if (r_state == IDLE && (w_grantD || w_grantI)) begin
        r_base  <= w_grantD ? d_addr[17:2] : i_addr[17:2];
        r_we    <= w_grantD && d_we;
        r_wdata <= d_wdata;
        r_be    <= d_be;
        r_isD   <= w_grantD;
        r_lastD <= w_grantD;
      end
      if (r_state == LO_RD) r_buf[15:0]  <= mem_data;
      if (r_state == HI_RD) r_buf[31:16] <= mem_data;
      if (r_state == HI_RD && !r_we) begin
        if (r_isD) r_dRdata <= {mem_data, r_buf[15:0]};
        else       r_iRdata <= {mem_data, r_buf[15:0]};
      end
    end
  end

endmodule

// File: tb/tb_dram16_arb_ctrl.sv
// tb_dram16_arb_ctrl: drives directed and random instruction/data traffic into
// dram16_arb_ctrl over a behavioural 16-bit DRAM and compares every response
// with a word-level reference memory and a round-robin arbitration model.
module tb_dram16_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [16:0] mem_addr;
  logic        mem_we;
  wire  [15:0] mem_data;

  logic [15:0] dram [0:131071];
  logic        clearMem;

  logic [15:0] refMem [0:63];
  bit          lastD;
  logic [31:0] lastIRdata;
  logic [31:0] lastDRdata;

  int testsRun = 0;
  int testsFailed = 0;

  // 100 MHz clock.
  always #5 clk = ~clk;

  dram16_arb_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_data (mem_data)
  );

  // Asynchronous-read DRAM: drives the bus only while the controller is not writing.
  assign mem_data = mem_we ? 16'bz : dram[mem_addr];

  // DRAM write port, plus a one-shot clear of the region the bench uses.
  always @(posedge clk) begin
    if (clearMem) begin
      for (int k = 0; k < 64; k++) dram[k] <= 16'h0000;
    end else if (mem_we) begin
      dram[mem_addr] <= mem_data;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Cycles from grant edge to ack: reads take LO, HI, RESP; stores pay 1 per
  // full halfword, 2 per partial halfword, 0 per empty one, plus RESP.
  function automatic int expLatency(input bit we, input logic [3:0] be);
    int lat;
    if (!we) return 3;
    lat = 1;
    for (int p = 0; p < 2; p++) begin
      if (be[2*p +: 2] == 2'b11)      lat += 1;
      else if (be[2*p +: 2] != 2'b00) lat += 2;
    end
    return lat;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] addr);
    int hw;
    hw = int'(addr[17:2]) * 2;
    return {refMem[hw + 1], refMem[hw]};
  endfunction

  task automatic refStore(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    int hw;
    hw = int'(addr[17:2]) * 2;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) refMem[hw + b / 2][8 * (b % 2) +: 8] = wdata[8 * b +: 8];
    end
  endtask

  // One transaction on the given port; entered at a negedge in IDLE with the
  // request raised, so the following posedge is the grant edge.
  task automatic runOne(input bit isD, input bit scramble);
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          we;
    logic [31:0] expData;
    logic [15:0] base;
    int          lat;
    int          expWr;
    int          n;
    int          wr;
    bit          acked;
    addr  = isD ? d_addr : i_addr;
    we    = isD ? d_we : 1'b0;
    wdata = d_wdata;
    be    = d_be;
    base  = addr[17:2];
    lat   = expLatency(we, be);
    expWr = we ? (int'(be[1:0] != 2'b00) + int'(be[3:2] != 2'b00)) : 0;
    expData = refLoad(addr);
    if (we) refStore(addr, wdata, be);
    lastD = isD;
    n = 0;
    wr = 0;
    acked = 1'b0;
    while (!acked && n < 12) begin
      @(negedge clk);
      n++;
      if (mem_we) wr++;
      if (!we && n == 1) checkOutput("memAddrLo", 32'(mem_addr), 32'({base, 1'b0}));
      if (!we && n == 2) checkOutput("memAddrHi", 32'(mem_addr), 32'({base, 1'b1}));
      if (n == 1 && scramble) begin
        if (isD) begin
          d_addr  = $urandom;
          d_wdata = $urandom;
          d_be    = 4'($urandom);
          d_we    = 1'($urandom);
          d_req   = 1'b0;
        end else begin
          i_addr = $urandom;
          i_req  = 1'b0;
        end
      end
      if (i_ack || d_ack) acked = 1'b1;
    end
    checkOutput("ackSeen", 32'(acked), 32'h1);
    checkOutput("latency", 32'(n), 32'(lat));
    checkOutput("ackPort", 32'({i_ack, d_ack}), isD ? 32'h1 : 32'h2);
    checkOutput("memWrites", 32'(wr), 32'(expWr));
    if (!we) begin
      if (isD) lastDRdata = expData;
      else     lastIRdata = expData;
    end
    checkOutput("dRdata", d_rdata, lastDRdata);
    checkOutput("iRdata", i_rdata, lastIRdata);
    if (isD) d_req = 1'b0;
    else     i_req = 1'b0;
    @(negedge clk);
    checkOutput("ackPulse", 32'({i_ack, d_ack}), 32'h0);
  endtask

  // One round of requests; on a conflict the model's round-robin pointer picks the order.
  task automatic applyStimulus(input bit useI, input bit useD,
                               input logic [31:0] iA, input logic [31:0] dA,
                               input bit we, input logic [31:0] wd,
                               input logic [3:0] be, input bit scrI, input bit scrD);
    i_addr  = iA;
    d_addr  = dA;
    d_we    = we;
    d_wdata = wd;
    d_be    = be;
    i_req   = useI;
    d_req   = useD;
    if (useI && useD) begin
      if (lastD) begin
        runOne(1'b0, scrI);
        runOne(1'b1, scrD);
      end else begin
        runOne(1'b1, scrD);
        runOne(1'b0, scrI);
      end
    end else if (useI) begin
      runOne(1'b0, scrI);
    end else if (useD) begin
      runOne(1'b1, scrD);
    end
  endtask

  task automatic randomRound();
    int pick;
    pick = $urandom_range(1, 3);
    applyStimulus(pick[0], pick[1], $urandom & 32'hFFFC_007F, $urandom & 32'hFFFC_007F,
                  1'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Main sequence: reset, directed scenarios, random traffic, reset mid-store.
  initial begin
    bit sawAck;
    rst_n    = 1'b0;
    clearMem = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    for (int k = 0; k < 64; k++) refMem[k] = 16'h0000;
    lastD = 1'b0;
    lastIRdata = 32'h0;
    lastDRdata = 32'h0;
    repeat (3) @(negedge clk);
    clearMem = 1'b0;
    checkOutput("rstIAck", 32'(i_ack), 32'h0);
    checkOutput("rstDAck", 32'(d_ack), 32'h0);
    checkOutput("rstIRdata", i_rdata, 32'h0);
    checkOutput("rstDRdata", d_rdata, 32'h0);
    checkOutput("rstMemWe", 32'(mem_we), 32'h0);
    checkOutput("rstMemAddr", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests: data first after reset, then alternating.
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1'b1, 1'b1, $urandom & 32'hFFFC_007F, $urandom & 32'hFFFC_007F,
                    1'($urandom), $urandom, 4'($urandom), 1'b0, 1'b0);
    end

    // Full-word store, then a single-byte read-modify-write and a load back.
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h10, 1'b1, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
    checkOutput("dram8Full", 32'(dram[8]), 32'h0000BEEF);
    checkOutput("dram9Full", 32'(dram[9]), 32'h0000DEAD);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h10, 1'b1, 32'h0000AA00, 4'b0010, 1'b0, 1'b0);
    checkOutput("dram8Rmw", 32'(dram[8]), 32'h0000AAEF);
    checkOutput("dram9Rmw", 32'(dram[9]), 32'h0000DEAD);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("loadRmw", d_rdata, 32'hDEADAAEF);

    // Empty store and an instruction fetch with ignored upper/low address bits.
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h14, 1'b1, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0004_0012, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("fetchWrap", i_rdata, 32'hDEADAAEF);

    for (int r = 0; r < 40; r++) randomRound();

    // Reset taken during the high-halfword write of a full-word store.
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h20; d_wdata = 32'h12345678; d_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    checkOutput("hiWrActive", 32'(mem_we), 32'h1);
    checkOutput("hiWrAddr", 32'(mem_addr), 32'h11);
    rst_n = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("rstMidDAck", 32'(d_ack), 32'h0);
    checkOutput("rstMidMemWe", 32'(mem_we), 32'h0);
    checkOutput("rstMidLoKept", 32'(dram[16]), 32'h00005678);
    checkOutput("rstMidDRdata", d_rdata, 32'h0);
    // The DRAM commits the high half on the same edge the reset is taken.
    refStore(32'h20, 32'h12345678, 4'hF);
    lastD = 1'b0;
    lastIRdata = 32'h0;
    lastDRdata = 32'h0;
    rst_n = 1'b1;
    sawAck = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack || i_ack) sawAck = 1'b1;
    end
    checkOutput("rstMidNoAck", 32'(sawAck), 32'h0);

    applyStimulus(1'b1, 1'b1, 32'h20, 32'h20, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int r = 0; r < 15; r++) randomRound();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dram16_arb_ctrl.md
DRAM16_ARB_CTRL -- requirements
Module: dram16_arb_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state changes on posedge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port i_req, input, 1: instruction-port read request, held until i_ack.
REQ-004 SHALL have port i_addr, input, 32: instruction byte address.
REQ-005 SHALL have port i_ack, output, 1: one-cycle completion pulse; i_rdata valid in this cycle.
REQ-006 SHALL have port i_rdata, output, 32: instruction read data.
REQ-007 SHALL have port d_req, input, 1: data-port request, held until d_ack.
REQ-008 SHALL have port d_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port d_addr, input, 32: data byte address.
REQ-010 SHALL have port d_wdata, input, 32: store data.
REQ-011 SHALL have port d_be, input, 4: store byte enables; bit n selects byte n.
REQ-012 SHALL have port d_ack, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port d_rdata, output, 32: load data, valid in the d_ack cycle.
REQ-014 SHALL have port mem_addr, output, 17: halfword index to the 16-bit DRAM.
REQ-015 SHALL have port mem_we, output, 1: DRAM write enable; DRAM writes at posedge while high.
REQ-016 SHALL have port mem_data, inout, 16: DRAM bus; read data is combinational from mem_addr while mem_we=0.

Function
REQ-017 SHALL form the word base as byte_addr[17:2]; byte_addr[1:0] and [31:18] ignored (wraps modulo 256 KiB).
REQ-018 SHALL use little-endian layout: low halfword mem_addr={base,0} holds bits 15:0; high halfword {base,1} holds bits 31:16.
REQ-019 SHALL implement states IDLE, LO_RD, LO_WR, HI_RD, HI_WR, RESP.
REQ-020 In IDLE, SHALL sample requests, grant one, and latch its addr, we, wdata and be at that edge; later requester changes have no effect on that transaction.
REQ-021 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not granted last; the data port wins the first conflict after reset.
REQ-022 For a single request, SHALL grant it regardless of the round-robin pointer; the pointer updates only on a grant.
REQ-023 Load/fetch SHALL sequence IDLE -> LO_RD -> HI_RD -> RESP, capturing mem_data at the end of each RD state; ack rises 3 cycles after the grant edge.
REQ-024 Store per halfword: be pair 11 -> WR only; 01 or 10 -> RD then WR (read-modify-write, unselected byte preserved); 00 -> halfword skipped.
REQ-025 Store with d_be=0000 SHALL issue no memory cycle: IDLE -> RESP.
REQ-026 mem_we SHALL be 1 only in LO_WR/HI_WR; mem_data SHALL be driven only when mem_we=1, else high-Z.
REQ-027 In RESP, SHALL pulse exactly one of i_ack/d_ack for one cycle, then go to IDLE; rdata SHALL hold its value until the next ack of that port.
REQ-028 A request dropped before ack SHALL still complete and be acknowledged; a store on the instruction port is impossible (i_req is read-only).
REQ-029 Back-to-back: after RESP, IDLE SHALL grant a pending request on the next edge; a full read occupies 4 cycles including IDLE.

Reset
REQ-030 While rst_n=0 at a posedge: state=IDLE, mem_we=0, mem_data high-Z, mem_addr=0, i_ack=d_ack=0, i_rdata=d_rdata=0, pointer favours data port.
REQ-031 Reset mid-transaction SHALL abandon it with no ack; a halfword written before reset stays written.

Verification
REQ-032 Store d_addr=0x10, wdata=0xDEADBEEF, be=1111 -> mem writes [8]=0xBEEF and [9]=0xDEAD; d_ack 3 cycles after grant.
REQ-033 Then store be=0010, wdata=0x0000AA00 -> LO_RD then LO_WR; [8]=0xAABEEF-style merge gives 0xAAEF; [9] untouched; load returns 0xDEADAAEF.
REQ-034 i_req and d_req rise in the same cycle, repeated 4 times -> grants alternate D,I,D,I; exactly one ack per RESP.
REQ-035 Store with be=0000 -> mem_we never high; d_ack 1 cycle after grant.
REQ-036 rst_n low during HI_WR of a full-word store -> no d_ack; next cycle mem_we=0 and the bus is high-Z; the low halfword keeps the new value.
REQ-037 i_addr=0x0004_0012 -> mem_addr 0x00008/0x00009 (upper bits and [1:0] ignored).
